// File: rtl/dds_nco.sv
// Phase-accumulator NCO: sine/square/saw/triangle shaping with phase offset and
// amplitude scaling. Retuning is deferred to the next accumulator wrap.
module dds_nco #(
    parameter int ACC_W        = 32,
    parameter int LUT_AW       = 8,
    parameter int OUT_W        = 16,
    parameter int AMP_W        = 9,
    parameter bit USE_LUT_DATA = 1'b0,
    parameter logic [(2**LUT_AW)*OUT_W-1:0] LUT_DATA = '0
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_en,
    input  logic                    i_sync_clr,
    input  logic                    i_cfg_valid,
    output logic                    o_cfg_ready,
    input  logic [ACC_W-1:0]        i_cfg_fword,
    input  logic [ACC_W-1:0]        i_cfg_poff,
    input  logic [1:0]              i_cfg_mode,
    input  logic [AMP_W-1:0]        i_cfg_amp,
    output logic                    o_wrap,
    output logic                    o_out_valid,
    output logic signed [OUT_W-1:0] o_out
);

    localparam int     LUT_N = 2**LUT_AW;
    localparam int     P_W   = OUT_W + AMP_W + 1;
    localparam longint SCALE = (64'sd1 <<< (OUT_W - 1)) - 64'sd1;

    // Odd Taylor series of sin(2*pi*j/LUT_N) in Q30 for j in the first quadrant.
    function automatic longint quarterSine(input int j);
        longint x, x2, term, s;
        x    = (longint'(j) * 64'sd3373259426 * 64'sd2) / longint'(LUT_N);
        x2   = (x * x) >>> 30;
        term = x;
        s    = x;
        for (int k = 1; k <= 4; k++) begin
            term = -((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
            s    = s + term;
        end
        return (s * SCALE + (64'sd1 <<< 29)) >>> 30;
    endfunction

    function automatic longint halfSine(input int m);
        return (m <= LUT_N / 4) ? quarterSine(m) : quarterSine(LUT_N / 2 - m);
    endfunction

    function automatic logic [LUT_N*OUT_W-1:0] genSine();
        logic [LUT_N*OUT_W-1:0] tbl;
        longint                 v;
        tbl = '0;
        for (int i = 0; i < LUT_N; i++) begin
            v = (i <= LUT_N / 2) ? halfSine(i) : -halfSine(i - LUT_N / 2);
            tbl[i*OUT_W +: OUT_W] = OUT_W'(v);
        end
        return tbl;
    endfunction

    localparam logic [LUT_N*OUT_W-1:0] LUT_TBL   = USE_LUT_DATA ? LUT_DATA : genSine();
    localparam logic [AMP_W-1:0]       AMP_UNITY = {1'b1, {(AMP_W-1){1'b0}}};
    localparam logic [OUT_W-1:0]       POS_FS    = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0]       NEG_FS    = {1'b1, {(OUT_W-2){1'b0}}, 1'b1};
    localparam logic [OUT_W-1:0]       SAT_LO    = {1'b1, {(OUT_W-1){1'b0}}};

    typedef enum logic {RUN, PEND} state_t;

    state_t                  r_state, w_state_nxt;
    logic [ACC_W-1:0]        r_acc, r_fword, r_poff, r_sh_fword, r_sh_poff, w_acc_sum;
    logic [1:0]              r_mode, r_sh_mode, r_s1_mode;
    logic [AMP_W-1:0]        r_amp, r_sh_amp, r_s1_amp, r_s2_amp;
    logic                    r_wrap, w_carry, w_load_direct, w_apply_shadow;
    logic                    r_v1, r_v2, r_v3;
    logic [OUT_W-1:0]        r_s1_t, w_tri, w_wave, r_s2_wave, w_sat;
    logic [LUT_AW-1:0]       w_idx;
    logic signed [P_W-1:0]   w_prod, w_scaled;
    logic signed [OUT_W-1:0] r_out;

    assign {w_carry, w_acc_sum} = {1'b0, r_acc} + {1'b0, r_fword};

    always_comb begin
        w_state_nxt    = r_state;
        o_cfg_ready    = 1'b0;
        w_load_direct  = 1'b0;
        w_apply_shadow = 1'b0;
        case (r_state)
            RUN: begin
                o_cfg_ready = 1'b1;
                if (i_cfg_valid) begin
                    if (i_en) w_state_nxt = PEND;
                    else      w_load_direct = 1'b1;
                end
            end
            PEND: begin
                // A running accumulator only retunes on the edge that carries out.
                if (!i_en || i_sync_clr || w_carry) begin
                    w_apply_shadow = 1'b1;
                    w_state_nxt    = RUN;
                end
            end
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= RUN;
            r_fword    <= '0;
            r_poff     <= '0;
            r_mode     <= '0;
            r_amp      <= AMP_UNITY;
            r_sh_fword <= '0;
            r_sh_poff  <= '0;
            r_sh_mode  <= '0;
            r_sh_amp   <= AMP_UNITY;
        end else begin
            r_state <= w_state_nxt;
            if (o_cfg_ready && i_cfg_valid) begin
                r_sh_fword <= i_cfg_fword;
                r_sh_poff  <= i_cfg_poff;
                r_sh_mode  <= i_cfg_mode;
                r_sh_amp   <= i_cfg_amp;
            end
            if (w_load_direct) begin
                r_fword <= i_cfg_fword;
                r_poff  <= i_cfg_poff;
                r_mode  <= i_cfg_mode;
                r_amp   <= i_cfg_amp;
            end else if (w_apply_shadow) begin
                r_fword <= r_sh_fword;
                r_poff  <= r_sh_poff;
                r_mode  <= r_sh_mode;
                r_amp   <= r_sh_amp;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_sync_clr) begin
            r_acc  <= '0;
            r_wrap <= 1'b0;
        end else if (i_en) begin
            r_acc  <= w_acc_sum;
            r_wrap <= w_carry;
        end else begin
            r_wrap <= 1'b0;
        end
    end

    assign w_idx = r_s1_t[OUT_W-1 -: LUT_AW];

    always_comb begin
        w_tri = r_s1_t[OUT_W-1] ? ~(r_s1_t << 1) : (r_s1_t << 1);
        case (r_s1_mode)
            2'd0:    w_wave = LUT_TBL[int'(w_idx) * OUT_W +: OUT_W];
            2'd1:    w_wave = r_s1_t[OUT_W-1] ? NEG_FS : POS_FS;
            2'd2:    w_wave = {~r_s1_t[OUT_W-1], r_s1_t[OUT_W-2:0]};
            default: w_wave = {~w_tri[OUT_W-1], w_tri[OUT_W-2:0]};
        endcase
    end

    assign w_prod   = $signed(r_s2_wave) * $signed({1'b0, r_s2_amp});
    assign w_scaled = w_prod >>> (AMP_W - 1);

    always_comb begin
        if (!w_scaled[P_W-1] && (|w_scaled[P_W-2:OUT_W-1]))
            w_sat = POS_FS;
        else if (w_scaled[P_W-1] && !(&w_scaled[P_W-2:OUT_W-1]))
            w_sat = SAT_LO;
        else
            w_sat = w_scaled[OUT_W-1:0];
    end

    // Mode and amplitude travel with each sample so a retune never mixes configs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_s1_t    <= '0;
            r_s1_mode <= '0;
            r_s1_amp  <= '0;
            r_v1      <= 1'b0;
            r_s2_wave <= '0;
            r_s2_amp  <= '0;
            r_v2      <= 1'b0;
            r_out     <= '0;
            r_v3      <= 1'b0;
        end else begin
            r_s1_t    <= OUT_W'((r_acc + r_poff) >> (ACC_W - OUT_W));
            r_s1_mode <= r_mode;
            r_s1_amp  <= r_amp;
            r_v1      <= i_en;
            r_s2_wave <= w_wave;
            r_s2_amp  <= r_s1_amp;
            r_v2      <= r_v1;
            if (r_v2) r_out <= w_sat;
            r_v3      <= r_v2;
        end
    end

    assign o_wrap      = r_wrap;
    assign o_out_valid = r_v3;
    assign o_out       = r_out;

endmodule

// File: tb/tb_dds_nco.sv
// Self-checking bench for dds_nco with an 8-entry sine table: directed scenarios
// followed by randomized traffic, every cycle compared against an arithmetic model.
module tb_dds_nco;

    localparam longint TWO32 = 64'sd4294967296;
    localparam logic [8*16-1:0] LUT_IMG = {16'hD2BF, 16'hC000, 16'hD2BF, 16'h0000,
                                           16'h2D41, 16'h4000, 16'h2D41, 16'h0000};

    logic              clk = 1'b0;
    logic              rstN, en, syncClr, cfgValid, cfgReady, wrap, outValid;
    logic [31:0]       cfgFword, cfgPoff;
    logic [1:0]        cfgMode;
    logic [8:0]        cfgAmp;
    logic signed [15:0] outSample;

    int total = 0;
    int bad   = 0;
    int lutRef [8] = '{0, 11585, 16384, 11585, 0, -11585, -16384, -11585};

    longint mAcc, mFword, mPoff, sFword, sPoff;
    int     mMode, mAmp, sMode, sAmp, mOut;
    bit     mPend, mWrap, mValid;
    int     pipeVal [$];
    bit     pipeV [$];

    dds_nco #(
        .ACC_W(32), .LUT_AW(3), .OUT_W(16), .AMP_W(9),
        .USE_LUT_DATA(1'b1), .LUT_DATA(LUT_IMG)
    ) dut (
        .i_clk(clk), .i_rst_n(rstN), .i_en(en), .i_sync_clr(syncClr),
        .i_cfg_valid(cfgValid), .o_cfg_ready(cfgReady),
        .i_cfg_fword(cfgFword), .i_cfg_poff(cfgPoff), .i_cfg_mode(cfgMode),
        .i_cfg_amp(cfgAmp), .o_wrap(wrap), .o_out_valid(outValid), .o_out(outSample)
    );

    always #5 clk = ~clk;

    // Waveform value for an absolute 32-bit phase, scaled by amp/256 with flooring and clamping.
    function automatic int waveOf(input longint ph, input int mode, input int amp);
        longint t, w, p;
        t = ph >> 16;
        case (mode)
            0:       w = lutRef[ph >> 29];
            1:       w = (ph >= TWO32 / 2) ? -32767 : 32767;
            2:       w = t - 32768;
            default: w = (t < 32768) ? 2 * t - 32768 : 98303 - 2 * t;
        endcase
        p = (w * amp) >>> 8;
        if (p > 32767)  p = 32767;
        if (p < -32768) p = -32768;
        return int'(p);
    endfunction

    task automatic modelReset();
        mAcc = 0; mFword = 0; mPoff = 0; mMode = 0; mAmp = 256;
        sFword = 0; sPoff = 0; sMode = 0; sAmp = 256;
        mPend = 0; mWrap = 0; mValid = 0; mOut = 0;
        pipeVal = '{0, 0};
        pipeV   = '{0, 0};
    endtask

    task automatic checkEq(input string tag, input longint got, input longint exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("[TB] FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic checkOutput();
        checkEq("out", longint'(outSample), longint'(mOut));
        checkEq("out_valid", longint'(outValid), longint'(mValid));
        checkEq("wrap", longint'(wrap), longint'(mWrap));
        checkEq("cfg_ready", longint'(cfgReady), longint'(!mPend));
    endtask

    task automatic applyStimulus(input bit r, input bit e, input bit s, input bit v,
                                 input logic [31:0] fw, input logic [31:0] po,
                                 input logic [1:0] md, input logic [8:0] am);
        rstN = r; en = e; syncClr = s; cfgValid = v;
        cfgFword = fw; cfgPoff = po; cfgMode = md; cfgAmp = am;
    endtask

    // Advance the model by one clock using the current inputs, then compare after the edge.
    task automatic tick();
        longint sum;
        bit     carry;
        if (!rstN) begin
            modelReset();
        end else begin
            pipeVal.push_back(waveOf((mAcc + mPoff) % TWO32, mMode, mAmp));
            pipeV.push_back(en);
            sum   = mAcc + mFword;
            carry = en && !syncClr && (sum >= TWO32);
            if (mPend) begin
                if (!en || syncClr || carry) begin
                    mFword = sFword; mPoff = sPoff; mMode = sMode; mAmp = sAmp;
                    mPend  = 0;
                end
            end else if (cfgValid) begin
                sFword = longint'(cfgFword); sPoff = longint'(cfgPoff);
                sMode  = int'(cfgMode);      sAmp  = int'(cfgAmp);
                if (en) mPend = 1;
                else begin
                    mFword = sFword; mPoff = sPoff; mMode = sMode; mAmp = sAmp;
                end
            end
            if (syncClr)  mAcc = 0;
            else if (en)  mAcc = sum % TWO32;
            mWrap  = carry;
            mValid = pipeV.pop_front();
            begin
                int v;
                v = pipeVal.pop_front();
                if (mValid) mOut = v;
            end
        end
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    // Zero the accumulator and load a config directly, then enable for two cycles so the
    // next tick shows the sample for phase 0.
    task automatic loadDirect(input logic [31:0] fw, input logic [31:0] po,
                              input logic [1:0] md, input logic [8:0] am);
        applyStimulus(1, 0, 1, 1, fw, po, md, am);
        tick();
        applyStimulus(1, 1, 0, 0, fw, po, md, am);
        tick();
        tick();
    endtask

    initial begin
        int cnt;
        int sq [4];
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 256);
        tick();
        tick();
        checkEq("rst_ready", longint'(cfgReady), 1);
        checkEq("rst_out", longint'(outSample), 0);
        checkEq("rst_valid", longint'(outValid), 0);

        $display("[TB] sine table playback");
        loadDirect(32'h2000_0000, 0, 0, 256);
        checkEq("t1_latency", longint'(outValid), 0);
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (wrap) cnt++;
            checkEq("t1_sine", longint'(outSample), longint'(lutRef[i % 8]));
        end
        checkEq("t1_wraps", cnt, 2);

        $display("[TB] retune deferred to wrap");
        applyStimulus(1, 1, 0, 1, 32'h1000_0000, 0, 0, 256);
        tick();
        checkEq("t2_ready_drop", longint'(cfgReady), 0);
        applyStimulus(1, 1, 0, 0, 32'h1000_0000, 0, 0, 256);
        for (int i = 0; i < 40; i++) begin
            tick();
            if (wrap) break;
        end
        checkEq("t2_wrap_seen", longint'(wrap), 1);
        checkEq("t2_ready_back", longint'(cfgReady), 1);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            cnt++;
            if (wrap) break;
        end
        checkEq("t2_period", cnt, 16);

        $display("[TB] square with saturation");
        sq = '{32767, 32767, -32768, -32768};
        loadDirect(32'h4000_0000, 0, 1, 511);
        for (int i = 0; i < 8; i++) begin
            tick();
            checkEq("t3_sq_hi", longint'(outSample), longint'(sq[i % 4]));
        end
        sq = '{16383, 16383, -16384, -16384};
        loadDirect(32'h4000_0000, 0, 1, 128);
        for (int i = 0; i < 8; i++) begin
            tick();
            checkEq("t3_sq_half", longint'(outSample), longint'(sq[i % 4]));
        end

        $display("[TB] sawtooth and phase offset");
        loadDirect(32'h1000_0000, 0, 2, 256);
        for (int i = 0; i < 18; i++) begin
            tick();
            checkEq("t4_saw", longint'(outSample), longint'((i % 16) * 4096 - 32768));
        end
        loadDirect(32'h1000_0000, 32'h8000_0000, 2, 256);
        for (int i = 0; i < 16; i++) begin
            tick();
            checkEq("t4_saw_off", longint'(outSample), longint'(((i + 8) % 16) * 4096 - 32768));
        end

        $display("[TB] triangle");
        loadDirect(32'h0800_0000, 0, 3, 256);
        for (int i = 0; i < 40; i++) tick();

        $display("[TB] sync clear");
        loadDirect(32'h2000_0000, 0, 0, 256);
        for (int i = 0; i < 5; i++) tick();
        applyStimulus(1, 1, 1, 0, 32'h2000_0000, 0, 0, 256);
        tick();
        checkEq("t5_wrap_clr", longint'(wrap), 0);
        applyStimulus(1, 1, 0, 0, 32'h2000_0000, 0, 0, 256);
        tick();
        tick();
        tick();
        checkEq("t5_restart", longint'(outSample), 0);
        tick();
        checkEq("t5_next", longint'(outSample), 11585);

        $display("[TB] reset while pending");
        applyStimulus(1, 1, 0, 1, 32'h1000_0000, 32'h8000_0000, 2, 100);
        tick();
        checkEq("t6_pend", longint'(cfgReady), 0);
        applyStimulus(0, 1, 0, 0, 32'h1000_0000, 32'h8000_0000, 2, 100);
        tick();
        checkEq("t6_ready", longint'(cfgReady), 1);
        checkEq("t6_out", longint'(outSample), 0);
        checkEq("t6_valid", longint'(outValid), 0);
        applyStimulus(1, 1, 0, 0, 32'h1000_0000, 32'h8000_0000, 2, 100);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (wrap) cnt++;
        end
        checkEq("t6_no_wrap", cnt, 0);
        checkEq("t6_out_hold", longint'(outSample), 0);

        $display("[TB] zero tuning word holds pending");
        applyStimulus(1, 1, 0, 1, 32'h2000_0000, 0, 2, 256);
        tick();
        applyStimulus(1, 1, 0, 0, 32'h2000_0000, 0, 2, 256);
        for (int i = 0; i < 12; i++) tick();
        checkEq("fw0_ready_held", longint'(cfgReady), 0);
        applyStimulus(1, 0, 0, 0, 32'h2000_0000, 0, 2, 256);
        tick();
        checkEq("fw0_ready_back", longint'(cfgReady), 1);
        applyStimulus(1, 1, 0, 0, 32'h2000_0000, 0, 2, 256);
        for (int i = 0; i < 12; i++) tick();

        $display("[TB] randomized traffic");
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] fw;
            case ($urandom_range(0, 3))
                0:       fw = 32'h0;
                1:       fw = 32'h1 << $urandom_range(26, 30);
                2:       fw = $urandom;
                default: fw = 32'hFFFF_FFFF - $urandom_range(0, 3);
            endcase
            applyStimulus($urandom_range(0, 199) != 0, $urandom_range(0, 9) != 0,
                          $urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0,
                          fw, $urandom, 2'($urandom_range(0, 3)), 9'($urandom_range(0, 511)));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
